seven_seg_capture: RTL and testbench

Passive reader for the multiplexed, active-low 7-segment display bus. It watches the anode and segment lines that drive the board display and waits for each digit to settle. It then decodes the segment pattern back to a 4-bit BCD value and stores it per digit position. It sits alongside the display driver as a self-check and readback monitor, flagging patterns that are not legal digits 0-9.

---
 rtl/seven_seg_capture.sv | 149 ++++++++++++++
 tb/tb_seven_seg_capture.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_capture.sv
// Passive readback monitor for a multiplexed, active-low 7-segment display bus.
// Waits for {an, seg} to settle, decodes the lit digit back to BCD and stores it per position.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | anodes not one-hot-low (blanked or overlapping), no capture
// ST_WAIT | one digit lit, counting stable cycles toward a capture
// ST_DONE | captured this stable period, waiting for the bus to change
module seven_seg_capture #(
   parameter int N_DIG  = 4,
   parameter int SETTLE = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N_DIG-1:0]   an,
   input  logic [6:0]         seg,
   output logic [4*N_DIG-1:0] digits,
   output logic [N_DIG-1:0]   digit_valid,
   output logic               frame_valid,
   output logic               err,
   output logic [7:0]         err_count
);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

   localparam logic [7:0]       CNT_MAX = 8'(SETTLE - 1);
   localparam logic [N_DIG-1:0] ONE     = N_DIG'(1);

   state_t             state, state_n;
   logic [N_DIG-1:0]   an_q, an_low, seen, seen_n, valid_n;
   logic [6:0]         seg_q;
   logic [7:0]         cnt, cnt_n, err_count_n;
   logic               change, one_hot, capture;
   logic               is_digit, is_blank, frame_n, err_n;
   logic [3:0]         dec_val;
   logic [4*N_DIG-1:0] digits_n;

   always_comb begin
      is_digit = 1'b1;
      is_blank = 1'b0;
      dec_val  = 4'd0;
      case (seg)
         7'b1000000: dec_val = 4'd0;
         7'b1111001: dec_val = 4'd1;
         7'b0100100: dec_val = 4'd2;
         7'b0110000: dec_val = 4'd3;
         7'b0011001: dec_val = 4'd4;
         7'b0010010: dec_val = 4'd5;
         7'b0000010: dec_val = 4'd6;
         7'b1111000: dec_val = 4'd7;
         7'b0000000: dec_val = 4'd8;
         7'b0010000: dec_val = 4'd9;
         7'b1111111: begin
            is_digit = 1'b0;
            is_blank = 1'b1;
         end
         default:    is_digit = 1'b0;
      endcase
   end

   // cnt_n is this cycle's stability count: 0 on the cycle of a change.
   always_comb begin
      an_low  = ~an;
      change  = ({an, seg} != {an_q, seg_q});
      one_hot = (an_low != '0) && ((an_low & (an_low - ONE)) == '0);

      if (change)
         cnt_n = 8'd0;
      else if (cnt == CNT_MAX)
         cnt_n = cnt;
      else
         cnt_n = cnt + 8'd1;

      state_n = state;
      capture = 1'b0;
      case (state)
         ST_IDLE: begin
            if (one_hot) state_n = ST_WAIT;
         end
         ST_WAIT: begin
            if (change) begin
               state_n = one_hot ? ST_WAIT : ST_IDLE;
            end else if (cnt_n == CNT_MAX) begin
               capture = 1'b1;
               state_n = ST_DONE;
            end
         end
         ST_DONE: begin
            if (change) state_n = one_hot ? ST_WAIT : ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_comb begin
      digits_n    = digits;
      valid_n     = digit_valid;
      seen_n      = seen;
      frame_n     = 1'b0;
      err_n       = 1'b0;
      err_count_n = err_count;
      if (capture) begin
         if (is_digit || is_blank) begin
            for (int i = 0; i < N_DIG; i++) begin
               if (an_low[i]) begin
                  if (is_digit) digits_n[4*i +: 4] = dec_val;
                  valid_n[i] = is_digit;
               end
            end
            seen_n = seen | an_low;
            if (&seen_n) begin
               frame_n = 1'b1;
               seen_n  = '0;
            end
         end else begin
            err_n = 1'b1;
            if (err_count != 8'hFF) err_count_n = err_count + 8'd1;
         end
      end
   end

   // an_q/seg_q reset to all-ones so the first lit digit after reset is a change.
   always_ff @(posedge clk) begin
      if (reset) begin
         an_q        <= '1;
         seg_q       <= '1;
         cnt         <= 8'd0;
         state       <= ST_IDLE;
         seen        <= '0;
         digits      <= '0;
         digit_valid <= '0;
         frame_valid <= 1'b0;
         err         <= 1'b0;
         err_count   <= 8'd0;
      end else begin
         an_q        <= an;
         seg_q       <= seg;
         cnt         <= cnt_n;
         state       <= state_n;
         seen        <= seen_n;
         digits      <= digits_n;
         digit_valid <= valid_n;
         frame_valid <= frame_n;
         err         <= err_n;
         err_count   <= err_count_n;
      end
   end

endmodule

// File: tb/tb_seven_seg_capture.sv
// Bench for seven_seg_capture: directed scenarios plus random bus traffic,
// checked against a run-length model of the display bus.
module tb_seven_seg_capture;

   localparam int N_DIG  = 4;
   localparam int SETTLE = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic [15:0] digits;
   logic [3:0]  digit_valid;
   logic        frame_valid, err;
   logic [7:0]  err_count;

   seven_seg_capture #(.N_DIG(N_DIG), .SETTLE(SETTLE)) dut (
      .clk(clk), .reset(reset), .an(an), .seg(seg),
      .digits(digits), .digit_valid(digit_valid),
      .frame_valid(frame_valid), .err(err), .err_count(err_count)
   );

   always #5 clk = ~clk;

   int checks = 0, passes = 0;
   int dut_frames = 0, dut_errs = 0, exp_frames = 0, exp_errs = 0, pulse_mis = 0;

   logic [6:0] pat [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

   // Model: a capture happens when a one-hot-low run of identical {an,seg} reaches SETTLE cycles.
   logic [10:0] prev = '1;
   int          run_len = 0, mp = 0, mk = 0;
   logic [15:0] m_digits = '0;
   logic [3:0]  m_valid = '0, m_seen = '0;
   logic [7:0]  m_errc = '0;
   logic        m_frame = 1'b0, m_err = 1'b0;

   always @(posedge clk) begin
      if (reset) begin
         prev = '1; run_len = 0; m_digits = '0; m_valid = '0; m_seen = '0;
         m_errc = '0; m_frame = 1'b0; m_err = 1'b0;
      end else begin
         m_frame = 1'b0;
         m_err   = 1'b0;
         if ({an, seg} == prev) begin
            if (run_len < 255) run_len++;
         end else begin
            run_len = 1;
         end
         prev = {an, seg};
         if (run_len == SETTLE && $countones(~an) == 1) begin
            mp = 0;
            for (int i = 0; i < 4; i++) if (!an[i]) mp = i;
            mk = -1;
            for (int j = 0; j < 10; j++) if (seg == pat[j]) mk = j;
            if (mk >= 0) begin
               m_digits[4*mp +: 4] = mk[3:0];
               m_valid[mp] = 1'b1;
               m_seen[mp]  = 1'b1;
            end else if (seg == 7'h7F) begin
               m_valid[mp] = 1'b0;
               m_seen[mp]  = 1'b1;
            end else begin
               m_err = 1'b1;
               exp_errs++;
               if (m_errc < 8'd255) m_errc = m_errc + 8'd1;
            end
            if (m_seen == 4'hF) begin
               m_frame = 1'b1;
               exp_frames++;
               m_seen = '0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (frame_valid === 1'b1) dut_frames++;
      if (err === 1'b1) dut_errs++;
      if (frame_valid !== m_frame || err !== m_err) pulse_mis++;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b1; an = '1; seg = '1;
      tick(3);
      checks++;
      if ({digits, digit_valid, frame_valid, err, err_count} !== 30'd0)
         $display("FAIL reset_hold got %h exp 0", {digits, digit_valid, frame_valid, err, err_count});
      else passes++;
      reset = 1'b0;
      tick(2);
      checks++;
      if ({digits, digit_valid, frame_valid, err, err_count} !== 30'd0)
         $display("FAIL reset_release got %h exp 0", {digits, digit_valid, frame_valid, err, err_count});
      else passes++;
   endtask

   task automatic test_single;
      an = 4'b1110; seg = 7'b0100100;
      tick(SETTLE - 1);
      checks++;
      if (digit_valid !== 4'b0000) $display("FAIL single_early valid got %b exp 0000", digit_valid);
      else passes++;
      tick(1);
      checks++;
      if (digit_valid !== 4'b0001) $display("FAIL single_valid got %b exp 0001", digit_valid);
      else passes++;
      checks++;
      if (digits[3:0] !== 4'd2) $display("FAIL single_digit got %0d exp 2", digits[3:0]);
      else passes++;
      checks++;
      if (err !== 1'b0 || err_count !== 8'd0) $display("FAIL single_err got %b/%0d exp 0/0", err, err_count);
      else passes++;
   endtask

   task automatic test_scan;
      int f0;
      f0 = dut_frames;
      for (int p = 0; p < 4; p++) begin
         an = ~(4'b0001 << p); seg = pat[p+1];
         tick(20);
      end
      checks++;
      if (digits !== 16'h4321) $display("FAIL scan_digits got %h exp 4321", digits);
      else passes++;
      checks++;
      if (dut_frames - f0 != 1) $display("FAIL scan_frame1 got %0d exp 1", dut_frames - f0);
      else passes++;
      checks++;
      if (digit_valid !== 4'hF) $display("FAIL scan_valid got %b exp 1111", digit_valid);
      else passes++;
      for (int p = 0; p < 4; p++) begin
         an = ~(4'b0001 << p); seg = pat[p+1];
         tick(20);
      end
      checks++;
      if (dut_frames - f0 != 2) $display("FAIL scan_frame2 got %0d exp 2", dut_frames - f0);
      else passes++;
   endtask

   task automatic test_toggle;
      an = 4'b1101; seg = pat[5];
      tick(20);
      checks++;
      if (digits[7:4] !== 4'd5) $display("FAIL toggle_pre got %0d exp 5", digits[7:4]);
      else passes++;
      seg = pat[2];
      tick(SETTLE - 1);
      seg = pat[3];
      tick(SETTLE - 1);
      checks++;
      if (digits[7:4] !== 4'd5) $display("FAIL toggle_no2 got %0d exp 5", digits[7:4]);
      else passes++;
      tick(1);
      checks++;
      if (digits[7:4] !== 4'd3) $display("FAIL toggle_cap3 got %0d exp 3", digits[7:4]);
      else passes++;
   endtask

   task automatic test_illegal;
      int e0, f0;
      e0 = dut_errs; f0 = dut_frames;
      an = 4'b1011; seg = 7'b0110110;
      tick(10);
      checks++;
      if (dut_errs - e0 != 1 || err_count !== 8'd1)
         $display("FAIL illegal_one got %0d/%0d exp 1/1", dut_errs - e0, err_count);
      else passes++;
      checks++;
      if (digit_valid[2] !== 1'b1 || digits[11:8] !== 4'd3)
         $display("FAIL illegal_keep got %b/%0d exp 1/3", digit_valid[2], digits[11:8]);
      else passes++;
      for (int k = 0; k < 299; k++) begin
         seg = (k % 2 == 0) ? 7'b0110111 : 7'b0110110;
         tick(9);
      end
      checks++;
      if (err_count !== 8'd255) $display("FAIL illegal_sat got %0d exp 255", err_count);
      else passes++;
      checks++;
      if (dut_errs - e0 != 300) $display("FAIL illegal_pulses got %0d exp 300", dut_errs - e0);
      else passes++;
      checks++;
      if (dut_frames != f0) $display("FAIL illegal_noframe got %0d exp %0d", dut_frames, f0);
      else passes++;
   endtask

   task automatic test_bad_an;
      int e0, f0;
      e0 = dut_errs; f0 = dut_frames;
      an = 4'b0011; seg = pat[8];
      tick(50);
      an = 4'b1111;
      tick(50);
      checks++;
      if (dut_errs != e0 || dut_frames != f0 || digits !== 16'h4331 || digit_valid !== 4'hF)
         $display("FAIL bad_an got err%0d frm%0d %h %b exp err%0d frm%0d 4331 1111",
                  dut_errs, dut_frames, digits, digit_valid, e0, f0);
      else passes++;
      an = 4'b0111; seg = 7'h7F;
      tick(10);
      checks++;
      if (digit_valid !== 4'b0111 || digits[15:12] !== 4'd4)
         $display("FAIL blank_pos3 got %b/%0d exp 0111/4", digit_valid, digits[15:12]);
      else passes++;
      an = 4'b1110; seg = pat[7];
      tick(10);
      checks++;
      if (dut_frames != f0) $display("FAIL blank_noframe got %0d exp %0d", dut_frames, f0);
      else passes++;
      an = 4'b1011; seg = pat[9];
      tick(10);
      checks++;
      if (dut_frames - f0 != 1) $display("FAIL blank_frame got %0d exp 1", dut_frames - f0);
      else passes++;
      checks++;
      if (digits !== m_digits || digit_valid !== m_valid)
         $display("FAIL blank_model got %h/%b exp %h/%b", digits, digit_valid, m_digits, m_valid);
      else passes++;
   endtask

   task automatic test_reset_mid;
      an = 4'b1101; seg = pat[6];
      tick(4);
      reset = 1'b1;
      tick(2);
      checks++;
      if ({digits, digit_valid, frame_valid, err, err_count} !== 30'd0)
         $display("FAIL rstmid_clear got %h exp 0", {digits, digit_valid, frame_valid, err, err_count});
      else passes++;
      reset = 1'b0;
      tick(SETTLE - 1);
      checks++;
      if (digit_valid !== 4'b0000) $display("FAIL rstmid_early got %b exp 0000", digit_valid);
      else passes++;
      tick(1);
      checks++;
      if (digit_valid !== 4'b0010 || digits[7:4] !== 4'd6)
         $display("FAIL rstmid_cap got %b/%0d exp 0010/6", digit_valid, digits[7:4]);
      else passes++;
   endtask

   task automatic test_random;
      int r;
      for (int n = 0; n < 300; n++) begin
         r = $urandom_range(0, 9);
         if (r < 7) an = ~(4'b0001 << $urandom_range(0, 3));
         else       an = 4'($urandom);
         r = $urandom_range(0, 19);
         if (r < 10)      seg = pat[$urandom_range(0, 9)];
         else if (r < 13) seg = 7'h7F;
         else             seg = 7'($urandom_range(0, 127));
         tick($urandom_range(1, 20));
         checks++;
         if (digits !== m_digits || digit_valid !== m_valid || err_count !== m_errc)
            $display("FAIL random_state n=%0d got %h/%b/%0d exp %h/%b/%0d",
                     n, digits, digit_valid, err_count, m_digits, m_valid, m_errc);
         else passes++;
      end
      checks++;
      if (dut_frames != exp_frames || dut_errs != exp_errs)
         $display("FAIL random_pulses got frm%0d err%0d exp frm%0d err%0d",
                  dut_frames, dut_errs, exp_frames, exp_errs);
      else passes++;
      checks++;
      if (pulse_mis != 0) $display("FAIL pulse_timing got %0d mismatched cycles exp 0", pulse_mis);
      else passes++;
   endtask

   initial begin
      reset = 1'b1; an = '1; seg = '1;
      test_reset();
      test_single();
      test_scan();
      test_toggle();
      test_illegal();
      test_bad_an();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
